// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types used by the fetch path.
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;
    localparam int          FQ_DEPTH  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x 64-bit array, synchronous write, combinational read.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];

    // No reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the program counter stage and decode.
module fetch_queue #(
    parameter int          DEPTH     = riscv_pkg::FQ_DEPTH,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset_in,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic                     fetch_valid_in,
    input  logic                     flush_in,
    input  logic                     dec_ready_in,
    output logic [31:0]              instr_out,
    output logic [31:0]              instr_pc_out,
    output logic                     instr_valid_out,
    output logic                     misaligned_instr_out,
    output logic                     stall_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    import riscv_pkg::fq_entry_t;
    import riscv_pkg::BOOT_ADDR;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    fq_entry_t     wr_entry;
    fq_entry_t     head;

    // Handshake: an entry transfers to decode on a rising edge where
    // instr_valid_out && dec_ready_in; the producer holds while stall_out=1,
    // and a push while full is only taken if the same edge also pops.
    assign full = (count == FULL_CNT);
    assign pop  = (count != '0) && dec_ready_in;
    assign push = fetch_valid_in && (!full || pop);

    assign wr_entry.pc    = pc_in;
    assign wr_entry.instr = instr_in;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush_in),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Empty queue presents a NOP at the boot address so decode sees a harmless word.
    assign instr_valid_out      = (count != '0);
    assign instr_out            = instr_valid_out ? head.instr : NOP_INSTR;
    assign instr_pc_out         = instr_valid_out ? head.pc : BOOT_ADDR;
    assign misaligned_instr_out = instr_valid_out && (instr_pc_out[1:0] != 2'b00);
    assign stall_out            = full;
    assign count_out            = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue at DEPTH=4.
module tb_fetch_queue;
    logic        clk;
    logic        reset_in;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        fetch_valid_in;
    logic        flush_in;
    logic        dec_ready_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_valid_out;
    logic        misaligned_instr_out;
    logic        stall_out;
    logic [2:0]  count_out;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];

    fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut (
        .clk                  (clk),
        .reset_in             (reset_in),
        .pc_in                (pc_in),
        .instr_in             (instr_in),
        .fetch_valid_in       (fetch_valid_in),
        .flush_in             (flush_in),
        .dec_ready_in         (dec_ready_in),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out),
        .instr_valid_out      (instr_valid_out),
        .misaligned_instr_out (misaligned_instr_out),
        .stall_out            (stall_out),
        .count_out            (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic rdy, input logic fl);
        fetch_valid_in = fv;
        pc_in          = pc;
        instr_in       = word_of(pc);
        dec_ready_in   = rdy;
        flush_in       = fl;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cycle();
        n_checks++;
        if (count_out !== 3'd0 || instr_valid_out !== 1'b0 || stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: count=%0d valid=%b stall=%b, required 0/0/0", count_out, instr_valid_out, stall_out);
        end
        n_checks++;
        if (instr_out !== 32'h0000_0013 || instr_pc_out !== 32'h0 || misaligned_instr_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: instr=%h pc=%h mis=%b, required 00000013/0/0", instr_out, instr_pc_out, misaligned_instr_out);
        end
        reset_in = 1'b0;
        // First edge after deassertion must accept a push.
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (count_out !== 3'd1 || instr_pc_out !== 32'h40) begin
            n_fail++;
            $display("FAIL first_push: count=%0d pc=%h, required 1/00000040", count_out, instr_pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            if (i == 0) begin
                n_checks++;
                if (instr_valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_bypass: valid=%b before push edge, required 0", instr_valid_out);
                end
            end
            cycle();
            if (i == 0) begin
                n_checks++;
                if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h0 || instr_out !== word_of(32'h0)) begin
                    n_fail++;
                    $display("FAIL latency: valid=%b pc=%h instr=%h, required 1/0/%h", instr_valid_out, instr_pc_out, instr_out, word_of(32'h0));
                end
            end
            if (i == 2) begin
                n_checks++;
                if (stall_out !== 1'b0 || count_out !== 3'd3) begin
                    n_fail++;
                    $display("FAIL not_full: stall=%b count=%0d, required 0/3", stall_out, count_out);
                end
            end
        end
        n_checks++;
        if (stall_out !== 1'b1 || count_out !== 3'd4) begin
            n_fail++;
            $display("FAIL full: stall=%b count=%0d, required 1/4", stall_out, count_out);
        end
        drive(1'b1, 32'h0000_0010, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (count_out !== 3'd4 || instr_pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL drop_push: count=%0d head=%h, required 4/00000000", count_out, instr_pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (instr_pc_out !== 32'(i * 4) || instr_out !== word_of(32'(i * 4))) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: pc=%h instr=%h, required %h/%h", i, instr_pc_out, instr_out, 32'(i * 4), word_of(32'(i * 4)));
            end
            cycle();
        end
        n_checks++;
        if (instr_valid_out !== 1'b0 || instr_out !== 32'h0000_0013 || instr_pc_out !== 32'h0 || stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_out: valid=%b instr=%h pc=%h stall=%b, required 0/00000013/0/0", instr_valid_out, instr_out, instr_pc_out, stall_out);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_simul_push_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0);
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_with_pop: stall=%b, required 1", stall_out);
        end
        cycle();
        n_checks++;
        if (count_out !== 3'd4 || instr_pc_out !== 32'h4) begin
            n_fail++;
            $display("FAIL full_pushpop: count=%0d head=%h, required 4/00000004", count_out, instr_pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (instr_pc_out !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL pushpop_order[%0d]: pc=%h, required %h", i, instr_pc_out, 32'(i * 4));
            end
            cycle();
        end
        n_checks++;
        if (count_out !== 3'd0) begin
            n_fail++;
            $display("FAIL pushpop_empty: count=%0d, required 0", count_out);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h0000_0050, 1'b1, 1'b1);
        cycle();
        n_checks++;
        if (count_out !== 3'd0 || instr_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: count=%0d valid=%b, required 0/0", count_out, instr_valid_out);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (count_out !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_push_absent: count=%0d, required 0", count_out);
        end
        drive(1'b1, 32'h0000_0060, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (count_out !== 3'd1 || instr_pc_out !== 32'h60) begin
            n_fail++;
            $display("FAIL post_flush: count=%0d head=%h, required 1/00000060", count_out, instr_pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned();
        drive(1'b1, 32'h0000_0102, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (misaligned_instr_out !== 1'b1 || instr_pc_out !== 32'h102) begin
            n_fail++;
            $display("FAIL misaligned_102: mis=%b pc=%h, required 1/00000102", misaligned_instr_out, instr_pc_out);
        end
        drive(1'b1, 32'h0000_0104, 1'b1, 1'b0);
        cycle();
        n_checks++;
        if (misaligned_instr_out !== 1'b0 || instr_pc_out !== 32'h104) begin
            n_fail++;
            $display("FAIL aligned_104: mis=%b pc=%h, required 0/00000104", misaligned_instr_out, instr_pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        exp_q.delete();
        drive(1'b1, 32'h0000_2000, 1'b0, 1'b0);
        exp_q.push_back(32'h0000_2000);
        cycle();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h0000_2000 + 32'(i * 4), 1'b1, 1'b0);
            exp_q.push_back(32'h0000_2000 + 32'(i * 4));
            exp = exp_q.pop_front();
            n_checks++;
            if (instr_pc_out !== exp || instr_out !== word_of(exp) || count_out !== 3'd1) begin
                n_fail++;
                $display("FAIL wrap[%0d]: pc=%h instr=%h count=%0d, required %h/%h/1", i, instr_pc_out, instr_out, count_out, exp, word_of(exp));
            end
            cycle();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (instr_pc_out !== exp) begin
            n_fail++;
            $display("FAIL wrap_last: pc=%h, required %h", instr_pc_out, exp);
        end
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        n_checks++;
        if (count_out !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_count: count=%0d, required 3", count_out);
        end
        drive(1'b1, 32'h0000_0070, 1'b1, 1'b0);
        #1;
        reset_in = 1'b1;
        #1;
        n_checks++;
        if (count_out !== 3'd0 || instr_out !== 32'h0000_0013 || instr_valid_out !== 1'b0 || stall_out !== 1'b0 || instr_pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d instr=%h valid=%b stall=%b pc=%h, required 0/00000013/0/0/0", count_out, instr_out, instr_valid_out, stall_out, instr_pc_out);
        end
        cycle();
        n_checks++;
        if (count_out !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_hold: count=%0d, required 0", count_out);
        end
        reset_in = 1'b0;
        drive(1'b1, 32'h0000_0070, 1'b0, 1'b0);
        cycle();
        n_checks++;
        if (count_out !== 3'd1 || instr_pc_out !== 32'h70) begin
            n_fail++;
            $display("FAIL post_reset_push: count=%0d head=%h, required 1/00000070", count_out, instr_pc_out);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_drain();
        test_simul_push_pop();
        test_flush();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; a power of two, at least 2.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the word driven when the queue is empty.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pc_in, input, 32 bits: fetch address from the program counter.
REQ-006 SHALL have port instr_in, input, 32 bits: instruction word fetched at pc_in.
REQ-007 SHALL have port fetch_valid_in, input, 1 bit: pc_in/instr_in pair is valid this cycle.
REQ-008 SHALL have port flush_in, input, 1 bit: wrong-prediction or trap flush.
REQ-009 SHALL have port dec_ready_in, input, 1 bit: decode accepts the head entry.
REQ-010 SHALL have port instr_out, output, 32 bits: head instruction.
REQ-011 SHALL have port instr_pc_out, output, 32 bits: head PC.
REQ-012 SHALL have port instr_valid_out, output, 1 bit: head entry valid.
REQ-013 SHALL have port misaligned_instr_out, output, 1 bit: head PC not word-aligned.
REQ-014 SHALL have port stall_out, output, 1 bit: queue full; drives the program counter's stall_in.
REQ-015 SHALL have port count_out, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-016 SHALL push {pc_in, instr_in} at the rising edge when fetch_valid_in=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-017 SHALL pop the head at the rising edge when instr_valid_out=1 and dec_ready_in=1.
REQ-018 SHALL, on a simultaneous push and pop, leave count unchanged, including at count=DEPTH and count=1.
REQ-019 SHALL drop a push attempted while full without a same-cycle pop, with no state change; the producer is expected to hold on stall_out.
REQ-020 SHALL give a pushed entry a latency of one cycle: it is visible at the head no earlier than the cycle after the push edge, with no combinational bypass.
REQ-021 SHALL drive instr_valid_out = (count != 0), combinationally from registered state.
REQ-022 SHALL drive instr_out=NOP_INSTR, instr_pc_out=0 and misaligned_instr_out=0 when empty.
REQ-023 SHALL drive misaligned_instr_out = instr_valid_out & (instr_pc_out[1:0] != 2'b00).
REQ-024 SHALL drive stall_out = (count == DEPTH), without regard to pop in the same cycle.
REQ-025 SHALL use read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH without gaps.
REQ-026 SHALL, when flush_in=1, set count and both pointers to 0 at the next edge and ignore any same-cycle push and pop.
REQ-027 SHALL not clear storage contents on flush; only the pointers and count are reset.
REQ-028 SHALL keep FIFO order: entries leave in exactly the order they were pushed.

Reset
REQ-029 SHALL, while reset_in=1, immediately force count=0, pointers=0, instr_valid_out=0, stall_out=0, instr_out=NOP_INSTR, instr_pc_out=0 and misaligned_instr_out=0.
REQ-030 SHALL abandon any push or pop in progress when reset is asserted mid-operation.
REQ-031 SHALL accept its first push at the first rising edge after reset_in deasserts.

Structure
REQ-032 SHALL take the constants NOP_INSTR (32'h0000_0013), BOOT_ADDR (32'h0000_0000) and the default DEPTH from the shared package riscv_pkg.
REQ-033 SHALL place storage in one sub-module, fetch_queue_mem: a DEPTH x 64-bit array with one synchronous write port and one combinational read port, and no reset.
REQ-034 SHALL keep pointer, count and flush control in fetch_queue itself.

Verification
REQ-035 SHALL check reset: assert reset_in mid-stream with count=3 -> count_out=0, instr_out=32'h0000_0013 and instr_valid_out=0 without waiting for a clock edge.
REQ-036 SHALL check fill then drain: push PCs 0x0, 0x4, 0x8, 0xC with dec_ready_in=0 -> stall_out=1 after the 4th edge and a 5th push is dropped; then dec_ready_in=1 -> PCs pop in order 0x0..0xC, then empty outputs.
REQ-037 SHALL check simultaneous push and pop: with the queue full, push 0x10 while popping -> count stays 4 and 0x10 is popped fifth.
REQ-038 SHALL check flush: count=3 with flush_in=1 and fetch_valid_in=1 in the same cycle -> count_out=0 next cycle and the flush-cycle push is absent.
REQ-039 SHALL check the misaligned flag: push pc_in=0x0000_0102 -> misaligned_instr_out=1 when it reaches the head, and 0 for pc_in=0x0000_0104.
REQ-040 SHALL check wrap-around: run 10 consecutive push/pop pairs at DEPTH=4 -> no loss or reordering across pointer wrap.
